// File: rtl/layer4_argmax.sv
// Layer-4 output classifier: snapshots all node activations, scans one per cycle, reports argmax.
// Optional ARGMAX_MARGIN_EN adds runner-up tracking and the margin output.
module layer4_argmax #(
    parameter int NUM_NODES = 15,
    parameter int DW        = 16,
    parameter int IW        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DW*NUM_NODES-1:0] nodes_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [IW-1:0]           class_idx,
    output logic [DW-1:0]           class_val,
    output logic                    out_valid,
`ifdef ARGMAX_MARGIN_EN
    output logic [DW-1:0]           margin,
`endif
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_snap [NUM_NODES];
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_best_idx;
    logic [DW-1:0] r_best_val;
    logic          r_last;
`ifdef ARGMAX_MARGIN_EN
    logic [DW-1:0] r_runner;
`endif

    logic [DW-1:0] w_cand;
    logic          w_gt;
    logic          w_eq;
    logic          w_at_end;

    assign w_cand   = r_snap[r_idx];
    assign w_gt     = w_cand > r_best_val;
    assign w_eq     = w_cand == r_best_val;
    assign w_at_end = r_idx == IW'(NUM_NODES - 1);
    assign in_ready = r_state == S_IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            for (int unsigned k = 0; k < NUM_NODES; k++) r_snap[k] <= '0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_last     <= 1'b0;
            class_idx  <= '0;
            class_val  <= '0;
            out_valid  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            r_runner   <= '0;
            margin     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < NUM_NODES; k++)
                            r_snap[k] <= nodes_in[DW*k +: DW];
                        r_idx      <= '0;
                        r_best_idx <= '0;
                        r_best_val <= '0;
                        r_last     <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
                        r_runner   <= '0;
`endif
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // r_last adds the publish cycle after the final compare so outputs stay registered
                    if (!r_last) begin
                        if (w_gt) begin
                            r_best_val <= w_cand;
                            r_best_idx <= r_idx;
                        end
`ifdef ARGMAX_MARGIN_EN
                        if (w_gt || w_eq)
                            r_runner <= r_best_val;
                        else if (w_cand > r_runner)
                            r_runner <= w_cand;
`endif
                        if (w_at_end)
                            r_last <= 1'b1;
                        else
                            r_idx <= r_idx + 1'b1;
                    end else begin
                        class_idx <= r_best_idx;
                        class_val <= r_best_val;
`ifdef ARGMAX_MARGIN_EN
                        margin    <= r_best_val - r_runner;
`endif
                        out_valid <= 1'b1;
                        r_last    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
